// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
// dmem_arb_pkg : shared FSM, owner and counter types for dmem_arbiter
// Rev 1.0
// ============================================================================
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } owner_t;

  // Wide enough to hold the largest read latency (4).
  localparam int CNT_W = 3;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`default_nettype none
// ============================================================================
// dmem_arb_pick : combinational winner select; round-robin ties with DMEM_ARB_RR_EN
// Rev 1.0
// ============================================================================
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] reqs,        // [0] cpu, [1] ext
  input  logic       last_owner,
  output logic       winner
);

  always_comb begin
    winner = OWN_CPU;
    if (reqs == 2'b10) begin
      winner = OWN_EXT;
    end
`ifdef DMEM_ARB_RR_EN
    else if (reqs == 2'b11) begin
      winner = (last_owner == OWN_CPU) ? OWN_EXT : OWN_CPU;
    end
`endif
  end

`ifndef DMEM_ARB_RR_EN
  // Fixed-priority build ignores history.
  logic w_unused_last_owner;
  assign w_unused_last_owner = last_owner;
`endif

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// dmem_arbiter : CPU / external port arbiter for a single data memory
// Rev 1.0 -- define DMEM_ARB_RR_EN for round-robin tie breaking
// ============================================================================
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
)
(
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_CNT = CNT_W'(RD_LAT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t            state_q;
  owner_t            owner_q;
  owner_t            last_owner_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cpu_gnt_q;
  logic              ext_gnt_q;
  logic              cpu_rvalid_q;
  logic              ext_rvalid_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic [DATA_W-1:0] ext_rdata_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              mem_we_q;
  logic              mem_re_q;
  logic              winner;

  dmem_arb_pick u_pick (
    .reqs       ({ext_req, cpu_req}),
    .last_owner (last_owner_q),
    .winner     (winner)
  );

  // The winner's command is captured in IDLE, so the memory strobes and the
  // grant are flops that are live exactly for the one ISSUE cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= OWN_CPU;
      last_owner_q <= OWN_EXT;
      cnt_q        <= '0;
      cpu_gnt_q    <= 1'b0;
      ext_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
    end else begin
      cpu_gnt_q    <= 1'b0;
      ext_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_req || ext_req) begin
            owner_q <= owner_t'(winner);
            state_q <= ST_ISSUE;
            if (winner == OWN_CPU) begin
              mem_addr_q  <= cpu_addr;
              mem_wdata_q <= cpu_wdata;
              mem_we_q    <= cpu_we;
              mem_re_q    <= ~cpu_we;
              cpu_gnt_q   <= 1'b1;
            end else begin
              mem_addr_q  <= ext_addr;
              mem_wdata_q <= ext_wdata;
              mem_we_q    <= ext_we;
              mem_re_q    <= ~ext_we;
              ext_gnt_q   <= 1'b1;
            end
          end
        end
        ST_ISSUE: begin
          last_owner_q <= owner_q;
          if (mem_re_q) begin
            cnt_q   <= LAT_CNT;
            state_q <= ST_WAIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_ONE;
          if (cnt_q == CNT_ONE) begin
            state_q <= ST_IDLE;
            if (owner_q == OWN_CPU) begin
              cpu_rdata_q  <= mem_rdata;
              cpu_rvalid_q <= 1'b1;
            end else begin
              ext_rdata_q  <= mem_rdata;
              ext_rvalid_q <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_gnt    = cpu_gnt_q;
  assign ext_gnt    = ext_gnt_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign ext_rvalid = ext_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign ext_rdata  = ext_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;

  // A write completes on its grant, a read on its response.
  assign cpu_stall = cpu_req & ~(cpu_gnt_q & cpu_we) & ~cpu_rvalid_q;

endmodule
`default_nettype wire
